// File: rtl/lcd_timing_generator_if.sv
// Panel-side bundle of the LCD timing generator: scan control inputs plus all timing/prefetch outputs.
// The master modport is the generator; the slave modport is whatever drives enable/duty and consumes timing.
interface lcd_timing_generator_if #(
    parameter int DW = 4
);
    logic          enable;
    logic [DW-1:0] duty;
    logic          de;
    logic          hsync;
    logic          vsync;
    logic [15:0]   pos_x;
    logic [15:0]   pos_y;
    logic [15:0]   next_x;
    logic [15:0]   next_y;
    logic          line_start;
    logic          frame_start;
    logic          adj;
    logic          mode;

    modport master (
        input  enable, duty,
        output de, hsync, vsync, pos_x, pos_y, next_x, next_y,
               line_start, frame_start, adj, mode
    );

    modport slave (
        output enable, duty,
        input  de, hsync, vsync, pos_x, pos_y, next_x, next_y,
               line_start, frame_start, adj, mode
    );
endinterface

// File: rtl/lcd_timing_generator.sv
// LCD/RGB panel timing generator: H/V scan counters, registered DE/HSYNC/VSYNC/strobes,
// a one-cycle-ahead prefetch coordinate and a glitch-free backlight PWM.
module lcd_timing_generator #(
    parameter int   H_ACTIVE         = 800,
    parameter int   H_FRONT          = 40,
    parameter int   H_SYNC           = 48,
    parameter int   H_BACK           = 40,
    parameter int   V_ACTIVE         = 480,
    parameter int   V_FRONT          = 13,
    parameter int   V_SYNC           = 3,
    parameter int   V_BACK           = 29,
    parameter logic HSYNC_ACTIVE     = 1'b0,
    parameter logic VSYNC_ACTIVE     = 1'b0,
    parameter int   CLOCK_FREQUENCY  = 40000000,
    parameter int   ADJUST_FREQUENCY = 250,
    parameter int   DUTY_STEPS       = 10
) (
    input  logic                   clock,
    input  logic                   reset_n,
    lcd_timing_generator_if.master bus
);
    localparam int HT    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW    = $clog2(DUTY_STEPS + 1);
    localparam int P_RAW = CLOCK_FREQUENCY / (ADJUST_FREQUENCY * DUTY_STEPS);
    localparam int P     = (P_RAW < 1) ? 1 : P_RAW;
    localparam int PW    = (P > 1) ? $clog2(P) : 1;
    localparam int SW    = (DUTY_STEPS > 1) ? $clog2(DUTY_STEPS) : 1;

    generate
        if (HT > 65535 || VT > 65535 || H_SYNC == 0 || V_SYNC == 0) begin : g_bad_cfg
            $error("lcd_timing_generator: period exceeds 16 bits or sync width is zero");
        end
    endgenerate

    localparam logic [15:0] H_LAST  = 16'(HT - 1);
    localparam logic [15:0] V_LAST  = 16'(VT - 1);
    localparam logic [15:0] H_ACT   = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT   = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG  = 16'(H_ACTIVE + H_FRONT);
    localparam logic [15:0] HS_END  = 16'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [15:0] VS_BEG  = 16'(V_ACTIVE + V_FRONT);
    localparam logic [15:0] VS_END  = 16'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [15:0]   h_cnt_q, v_cnt_q, h_cnt_d, v_cnt_d;
    logic          run_q;
    logic          de_q, hsync_q, vsync_q, line_start_q, frame_start_q;
    logic [15:0]   pos_x_q, pos_y_q;
    logic          active, hs_on, vs_on;

    // run_q delays counting by one cycle after enable rises so the first (0,0) is shown as next first.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!bus.enable) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (run_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 16'd0 : v_cnt_q + 16'd1;
            end else begin
                h_cnt_d = h_cnt_q + 16'd1;
            end
        end
    end

    assign active = run_q && bus.enable;
    assign hs_on  = active && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs_on  = active && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            run_q         <= 1'b0;
            de_q          <= 1'b0;
            hsync_q       <= ~HSYNC_ACTIVE;
            vsync_q       <= ~VSYNC_ACTIVE;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            run_q         <= bus.enable;
            de_q          <= active && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
            hsync_q       <= hs_on ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
            vsync_q       <= vs_on ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
            line_start_q  <= active && (h_cnt_q == 16'd0);
            frame_start_q <= active && (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
            pos_x_q       <= h_cnt_q;
            pos_y_q       <= v_cnt_q;
        end
    end

    logic [PW-1:0] pre_q;
    logic [SW-1:0] step_q;
    logic [DW-1:0] duty_q, duty_sat;
    logic          adj_q;
    logic          tick;

    assign tick     = (pre_q == PW'(P - 1));
    assign duty_sat = (bus.duty > DW'(DUTY_STEPS)) ? DW'(DUTY_STEPS) : bus.duty;

    // New duty is only accepted on the tick that wraps the step counter, so a period is never cut short.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            step_q <= '0;
            duty_q <= '0;
            adj_q  <= 1'b0;
        end else begin
            adj_q <= (32'(step_q) < 32'(duty_q));
            if (tick) begin
                pre_q <= '0;
                if (step_q == SW'(DUTY_STEPS - 1)) begin
                    step_q <= '0;
                    duty_q <= duty_sat;
                end else begin
                    step_q <= step_q + SW'(1);
                end
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

    assign bus.de          = de_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.pos_x       = pos_x_q;
    assign bus.pos_y       = pos_y_q;
    assign bus.next_x      = h_cnt_q;
    assign bus.next_y      = v_cnt_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.adj         = adj_q;
    assign bus.mode        = 1'b1;
endmodule
